// File: rtl/pu_inst_fetch_queue_pkg.sv
// Shared types for the PU instruction fetch queue.
//   Inst        : one 32-bit instruction word
//   INST_NOP    : canonical no-op (ori 0,0,0), shown on out_inst when the queue is empty
//   Inst_class  : predecoded instruction class stored alongside each queue entry
//   OP_* / XO_* : primary opcode and extended opcode values used by predecode
package pu_inst_fetch_queue_pkg;

  typedef logic [31:0] Inst;

  localparam Inst INST_NOP = 32'h6000_0000;

  typedef enum logic [2:0] {
    Cls_alu     = 3'd0,
    Cls_branch  = 3'd1,
    Cls_load    = 3'd2,
    Cls_store   = 3'd3,
    Cls_fxv     = 3'd4,
    Cls_sys     = 3'd5,
    Cls_illegal = 3'd6
  } Inst_class;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_TWI     = 6'd3;
  localparam logic [5:0] OP_NVE_XO  = 6'd4;
  localparam logic [5:0] OP_NVECMPI = 6'd5;
  localparam logic [5:0] OP_BC      = 6'd16;
  localparam logic [5:0] OP_BRANCH  = 6'd18;
  localparam logic [5:0] OP_BCLR    = 6'd19;
  localparam logic [5:0] OP_X       = 6'd31;
  localparam logic [5:0] OP_LWZ     = 6'd32;
  localparam logic [5:0] OP_LWZU    = 6'd33;
  localparam logic [5:0] OP_LBZ     = 6'd34;
  localparam logic [5:0] OP_LBZU    = 6'd35;
  localparam logic [5:0] OP_STW     = 6'd36;
  localparam logic [5:0] OP_STWU    = 6'd37;
  localparam logic [5:0] OP_STB     = 6'd38;
  localparam logic [5:0] OP_STBU    = 6'd39;
  localparam logic [5:0] OP_LHZ     = 6'd40;
  localparam logic [5:0] OP_LHZU    = 6'd41;
  localparam logic [5:0] OP_LHA     = 6'd42;
  localparam logic [5:0] OP_LHAU    = 6'd43;
  localparam logic [5:0] OP_STH     = 6'd44;
  localparam logic [5:0] OP_STHU    = 6'd45;
  localparam logic [5:0] OP_LMW     = 6'd46;
  localparam logic [5:0] OP_STMW    = 6'd47;

  // Extended opcodes under OP_BCLR (inst[10:1])
  localparam logic [9:0] XO_RFMCI = 10'd38;
  localparam logic [9:0] XO_RFI   = 10'd50;
  localparam logic [9:0] XO_RFCI  = 10'd51;

  // Extended opcodes under OP_X (inst[10:1])
  localparam logic [9:0] XO_TW    = 10'd4;
  localparam logic [9:0] XO_LWZX  = 10'd23;
  localparam logic [9:0] XO_LWZUX = 10'd55;
  localparam logic [9:0] XO_WAIT  = 10'd62;
  localparam logic [9:0] XO_MFMSR = 10'd83;
  localparam logic [9:0] XO_LBZX  = 10'd87;
  localparam logic [9:0] XO_LBZUX = 10'd119;
  localparam logic [9:0] XO_MTMSR = 10'd146;
  localparam logic [9:0] XO_STWX  = 10'd151;
  localparam logic [9:0] XO_STWUX = 10'd183;
  localparam logic [9:0] XO_STBX  = 10'd215;
  localparam logic [9:0] XO_STBUX = 10'd247;
  localparam logic [9:0] XO_LHZX  = 10'd279;
  localparam logic [9:0] XO_LHZUX = 10'd311;
  localparam logic [9:0] XO_MFSPR = 10'd339;
  localparam logic [9:0] XO_LHAX  = 10'd343;
  localparam logic [9:0] XO_LHAUX = 10'd375;
  localparam logic [9:0] XO_STHX  = 10'd407;
  localparam logic [9:0] XO_STHUX = 10'd439;
  localparam logic [9:0] XO_MTSPR = 10'd467;
  localparam logic [9:0] XO_SYNC  = 10'd598;

endpackage

// File: rtl/pu_inst_fetch_queue_predecode.sv
// Combinational predecoder: classifies one instruction word from its primary
// opcode and extended opcode fields.
//   inst : instruction word
//   cls  : Inst_class encoding
module pu_inst_predecode
  import pu_inst_fetch_queue_pkg::*;
(
  input  logic [31:0] inst,
  output logic [2:0]  cls
);

  logic [5:0] op;
  logic [9:0] xo;
  logic       unused_fields;
  Inst_class  cls_dec;

  assign op            = inst[31:26];
  assign xo            = inst[10:1];
  assign unused_fields = ^{inst[25:11], inst[0]};

  always_comb begin
    cls_dec = Cls_alu;
    case (op)
      OP_BC, OP_BRANCH: cls_dec = Cls_branch;
      // The whole XL-form opcode is treated as branch-class except the
      // interrupt returns, which change machine state.
      OP_BCLR: begin
        case (xo)
          XO_RFI, XO_RFCI, XO_RFMCI: cls_dec = Cls_sys;
          default:                   cls_dec = Cls_branch;
        endcase
      end
      OP_LWZ, OP_LWZU, OP_LBZ, OP_LBZU,
      OP_LHZ, OP_LHZU, OP_LHA, OP_LHAU, OP_LMW:     cls_dec = Cls_load;
      OP_STW, OP_STWU, OP_STB, OP_STBU,
      OP_STH, OP_STHU, OP_STMW:                     cls_dec = Cls_store;
      OP_NVE_XO, OP_NVECMPI:                        cls_dec = Cls_fxv;
      OP_TWI:                                       cls_dec = Cls_sys;
      OP_X: begin
        case (xo)
          XO_LWZX, XO_LWZUX, XO_LBZX, XO_LBZUX,
          XO_LHZX, XO_LHZUX, XO_LHAX, XO_LHAUX:     cls_dec = Cls_load;
          XO_STWX, XO_STWUX, XO_STBX, XO_STBUX,
          XO_STHX, XO_STHUX:                        cls_dec = Cls_store;
          XO_WAIT, XO_SYNC, XO_MTMSR, XO_MFMSR,
          XO_MTSPR, XO_MFSPR, XO_TW:                cls_dec = Cls_sys;
          default:                                  cls_dec = Cls_alu;
        endcase
      end
      6'd0, 6'd1, 6'd2, 6'd17, 6'd22, 6'd30:        cls_dec = Cls_illegal;
      default: cls_dec = (op >= 6'd48) ? Cls_illegal : Cls_alu;
    endcase
  end

  assign cls = cls_dec;

endmodule

// File: rtl/pu_inst_fetch_queue.sv
// Instruction fetch queue between I-mem fetch and decode.
// Fetch beats of FETCH_WIDTH words are compacted by slot mask into a DEPTH-entry
// circular buffer; each word is predecoded on the way in. Decode pops one entry
// per cycle with valid/ready. flush empties the queue.
//   clk, reset(async, active-low), flush
//   in_valid/in_ready, in_pc, in_inst, in_mask    : fetch side
//   out_valid/out_ready, out_inst, out_pc, out_class : decode side
//   level                                         : occupied entries
module pu_inst_fetch_queue
  import pu_inst_fetch_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int DEPTH       = 8,
  parameter int PC_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PC_WIDTH-1:0]       in_pc,
  input  logic [FETCH_WIDTH*32-1:0] in_inst,
  input  logic [FETCH_WIDTH-1:0]    in_mask,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_inst,
  output logic [PC_WIDTH-1:0]       out_pc,
  output logic [2:0]                out_class,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [LVL_W-1:0]    level_next;
  logic [LVL_W-1:0]    push_cnt;
  logic                push_en;
  logic                pop_en;

  logic [31:0]         slot_inst [FETCH_WIDTH];
  logic [PC_WIDTH-1:0] slot_pc   [FETCH_WIDTH];
  logic [2:0]          slot_cls  [FETCH_WIDTH];
  logic [PTR_W-1:0]    wr_idx    [FETCH_WIDTH];

  logic [31:0]         mem_inst  [DEPTH];
  logic [PC_WIDTH-1:0] mem_pc    [DEPTH];
  logic [2:0]          mem_cls   [DEPTH];

  // Push side: slot split, pc per slot, predecode
  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_slot
    assign slot_inst[g] = in_inst[32*g +: 32];
    assign slot_pc[g]   = in_pc + PC_WIDTH'(4 * g);

    pu_inst_predecode u_predecode (
      .inst (slot_inst[g]),
      .cls  (slot_cls[g])
    );
  end

  // Compaction: each slot lands at wr_ptr plus the number of set mask bits
  // below it; the running total is the beat's word count.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_idx[i] = wr_ptr + push_cnt[PTR_W-1:0];
      push_cnt  = push_cnt + LVL_W'(in_mask[i]);
    end
  end

  // Ready depends only on registered level so no combinational path crosses the queue.
  assign in_ready  = (level <= LVL_W'(DEPTH - FETCH_WIDTH));
  assign out_valid = (level != '0);
  assign push_en   = in_valid & in_ready & ~flush;
  assign pop_en    = out_valid & out_ready & ~flush;

  always_comb begin
    level_next = level;
    if (push_en) level_next = level_next + push_cnt;
    if (pop_en)  level_next = level_next - LVL_W'(1);
  end

  // Control state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + push_cnt[PTR_W-1:0];
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_next;
    end
  end

  // Storage: contents are only meaningful below level, so no reset needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (push_en && in_mask[i]) begin
        mem_inst[wr_idx[i]] <= slot_inst[i];
        mem_pc[wr_idx[i]]   <= slot_pc[i];
        mem_cls[wr_idx[i]]  <= slot_cls[i];
      end
    end
  end

  // Head outputs: forced to idle values while empty, which also makes them
  // follow reset immediately.
  assign out_inst  = out_valid ? mem_inst[rd_ptr] : INST_NOP;
  assign out_pc    = out_valid ? mem_pc[rd_ptr]   : '0;
  assign out_class = out_valid ? mem_cls[rd_ptr]  : 3'(Cls_alu);

endmodule

// File: tb/tb_pu_inst_fetch_queue.sv
module tb_pu_inst_fetch_queue;

  localparam int FW    = 2;
  localparam int DEPTH = 8;
  localparam int PCW   = 32;

  localparam logic [31:0] NOP    = 32'h6000_0000;
  localparam logic [31:0] I_WAIT = 32'h7c00_007c;
  localparam logic [31:0] I_ADDI = 32'h3860_0005;
  localparam logic [31:0] I_LWZ  = 32'h8064_0000;
  localparam logic [2:0]  C_ALU = 3'd0, C_BR = 3'd1, C_LD = 3'd2, C_ST = 3'd3,
                          C_FXV = 3'd4, C_SYS = 3'd5, C_ILL = 3'd6;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [PCW-1:0] in_pc = '0;
  logic [FW*32-1:0] in_inst = '0;
  logic [FW-1:0]  in_mask = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [31:0]    out_inst;
  logic [PCW-1:0] out_pc;
  logic [2:0]     out_class;
  logic [3:0]     level;

  pu_inst_fetch_queue #(.FETCH_WIDTH(FW), .DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .out_class (out_class),
    .level     (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  cls;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] tbl_inst [16];
  logic [2:0]  tbl_cls  [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".level"},    64'(level),     64'(q.size()));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
    chk({tag, ".in_ready"}, 64'(in_ready),  64'((DEPTH - q.size()) >= FW));
    if (q.size() != 0) begin
      chk({tag, ".out_inst"},  64'(out_inst),  64'(q[0].inst));
      chk({tag, ".out_pc"},    64'(out_pc),    64'(q[0].pc));
      chk({tag, ".out_class"}, 64'(out_class), 64'(q[0].cls));
    end else begin
      chk({tag, ".out_inst"},  64'(out_inst),  64'(NOP));
      chk({tag, ".out_pc"},    64'(out_pc),    64'd0);
      chk({tag, ".out_class"}, 64'(out_class), 64'(C_ALU));
    end
  endtask

  // One clock: drive, let the model decide acceptance, update scoreboard, check.
  task automatic cycle(input bit v, input logic [31:0] pc, input logic [63:0] insts,
                       input logic [5:0] cls, input logic [1:0] mask,
                       input bit rdy, input bit fl, input string tag);
    bit push, pop;
    in_valid = v; in_pc = pc; in_inst = insts; in_mask = mask;
    out_ready = rdy; flush = fl;
    push = v && !fl && ((DEPTH - q.size()) >= FW);
    pop  = rdy && !fl && (q.size() != 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        for (int s = 0; s < FW; s++) begin
          if (mask[s]) q.push_back('{insts[32*s +: 32], pc + 32'(4 * s), cls[3*s +: 3]});
        end
      end
    end
    #1;
    check_outs(tag);
  endtask

  task automatic idle(input bit rdy, input string tag);
    cycle(1'b0, 32'h0, 64'h0, 6'h0, 2'b00, rdy, 1'b0, tag);
  endtask

  initial begin
    tbl_inst[0]  = 32'h3860_0005; tbl_cls[0]  = C_ALU;  // addi
    tbl_inst[1]  = 32'h8064_0000; tbl_cls[1]  = C_LD;   // lwz
    tbl_inst[2]  = 32'h9064_0000; tbl_cls[2]  = C_ST;   // stw
    tbl_inst[3]  = 32'h4800_0010; tbl_cls[3]  = C_BR;   // b
    tbl_inst[4]  = 32'h4082_0008; tbl_cls[4]  = C_BR;   // bc
    tbl_inst[5]  = 32'h7c64_282e; tbl_cls[5]  = C_LD;   // lwzx
    tbl_inst[6]  = 32'h7c64_292e; tbl_cls[6]  = C_ST;   // stwx
    tbl_inst[7]  = 32'h7c68_02a6; tbl_cls[7]  = C_SYS;  // mfspr
    tbl_inst[8]  = 32'h7c00_04ac; tbl_cls[8]  = C_SYS;  // sync
    tbl_inst[9]  = 32'h0000_0000; tbl_cls[9]  = C_ILL;  // opcode 0
    tbl_inst[10] = 32'hf000_0000; tbl_cls[10] = C_ILL;  // opcode 60
    tbl_inst[11] = 32'h1000_0000; tbl_cls[11] = C_FXV;  // nve xo-form
    tbl_inst[12] = 32'h0c00_0000; tbl_cls[12] = C_SYS;  // twi
    tbl_inst[13] = 32'h4c00_0064; tbl_cls[13] = C_SYS;  // rfi
    tbl_inst[14] = 32'h7c64_2a14; tbl_cls[14] = C_ALU;  // add
    tbl_inst[15] = 32'h4e80_0020; tbl_cls[15] = C_BR;   // bclr

    // Reset held for 3 cycles
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset");
    reset = 1'b1;
    idle(1'b0, "post_reset");

    // Two-word beat, then pop
    cycle(1'b1, 32'h100, {I_WAIT, I_ADDI}, {C_SYS, C_ALU}, 2'b11, 1'b0, 1'b0, "push2");
    idle(1'b1, "pop_first");
    idle(1'b1, "pop_second");

    // Sparse mask: only slot 1
    cycle(1'b1, 32'h200, {I_LWZ, I_ADDI}, {C_LD, C_ALU}, 2'b10, 1'b0, 1'b0, "sparse");
    idle(1'b1, "sparse_pop");

    // Fill from pointer 0, hold a 5th beat, then drain two
    cycle(1'b0, 32'h0, 64'h0, 6'h0, 2'b00, 1'b0, 1'b1, "realign_flush");
    for (int b = 0; b < 4; b++)
      cycle(1'b1, 32'h1000 + 32'(8 * b), {tbl_inst[2*b+1], tbl_inst[2*b]},
            {tbl_cls[2*b+1], tbl_cls[2*b]}, 2'b11, 1'b0, 1'b0, "fill");
    cycle(1'b1, 32'h2000, {tbl_inst[9], tbl_inst[8]}, {tbl_cls[9], tbl_cls[8]},
          2'b11, 1'b0, 1'b0, "held_beat");
    cycle(1'b1, 32'h2000, {tbl_inst[9], tbl_inst[8]}, {tbl_cls[9], tbl_cls[8]},
          2'b11, 1'b1, 1'b0, "held_pop1");
    idle(1'b1, "pop2");

    // Wrapped write (entries 0,1) with simultaneous pop, then drain in order
    cycle(1'b1, 32'h3000, {tbl_inst[11], tbl_inst[10]}, {tbl_cls[11], tbl_cls[10]},
          2'b11, 1'b1, 1'b0, "wrap_push_pop");
    for (int k = 0; k < 10; k++) idle(1'b1, "drain");

    // Build level 5, then flush with push and pop pending
    cycle(1'b1, 32'h4000, {tbl_inst[13], tbl_inst[12]}, {tbl_cls[13], tbl_cls[12]}, 2'b11, 1'b0, 1'b0, "pre_flush");
    cycle(1'b1, 32'h4008, {tbl_inst[15], tbl_inst[14]}, {tbl_cls[15], tbl_cls[14]}, 2'b11, 1'b0, 1'b0, "pre_flush");
    cycle(1'b1, 32'h4010, {tbl_inst[1],  tbl_inst[0]},  {tbl_cls[1],  tbl_cls[0]},  2'b01, 1'b0, 1'b0, "pre_flush");
    cycle(1'b1, 32'h5000, {I_WAIT, I_ADDI}, {C_SYS, C_ALU}, 2'b11, 1'b1, 1'b1, "flush");
    idle(1'b0, "after_flush");

    // Randomised traffic: arbitrary masks, backpressure, occasional flush
    begin
      logic [31:0] pc_ctr = 32'h8000;
      for (int c = 0; c < 200; c++) begin
        int i0, i1;
        i0 = $urandom_range(0, 15);
        i1 = $urandom_range(0, 15);
        cycle(($urandom_range(0, 3) != 0), pc_ctr, {tbl_inst[i1], tbl_inst[i0]},
              {tbl_cls[i1], tbl_cls[i0]}, 2'($urandom_range(0, 3)),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0), "rand");
        pc_ctr = pc_ctr + 32'd8;
      end
    end

    // Asynchronous reset mid-operation
    cycle(1'b1, 32'h9000, {I_LWZ, I_ADDI}, {C_LD, C_ALU}, 2'b11, 1'b0, 1'b0, "pre_areset");
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    q.delete();
    #1;
    check_outs("async_reset");
    @(posedge clk);
    #2;
    reset = 1'b1;
    idle(1'b0, "after_areset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
